// File: rtl/req_encoder4.sv
// req_encoder4: registered 4-to-2 request encoder with pending mask and valid/ready offer.
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   req_in[3:0]  - request pulses, each sets its pending bit at a clock edge
//   clr          - synchronous flush of pending mask and offer
//   ready_in     - consumer accepts code_out this cycle
//   code_out[1:0]- encoded index of the offered request
//   valid_out    - code_out is valid
//   pending_out  - current pending mask
//   overflow_out - one-cycle pulse when a request merges into an already-pending bit
module req_encoder4 #(
  parameter int ROUND_ROBIN = 0,
  parameter int N_REQ = 4,
  parameter int CODE_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic       clr,
  input  logic       ready_in,
  output logic [1:0] code_out,
  output logic       valid_out,
  output logic [3:0] pending_out,
  output logic       overflow_out
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_d;
  logic [3:0] pending, acc_mask, pend_next;
  logic [1:0] code, code_d, last;
  logic       ovf, acc;
  // Rotating mode scans base+1, base+2, ... so the base itself has lowest priority;
  // scanning downward lets the nearest hit overwrite farther ones.
  function automatic logic [1:0] sel(input logic [3:0] p, input logic [1:0] base);
    logic [1:0] r, k;
    r = 2'd0;
    if (ROUND_ROBIN != 0) begin
      for (int i = 4; i >= 1; i--) begin
        k = base + 2'(i);
        if (p[k]) r = k;
      end
    end else begin
      for (int i = 0; i < 4; i++) if (p[i]) r = 2'(i);
    end
    return r;
  endfunction
  assign valid_out    = state == OFFER;
  assign code_out     = code;
  assign pending_out  = pending;
  assign overflow_out = ovf;
  assign acc          = valid_out & ready_in;
  always_comb begin
    acc_mask  = acc ? 4'b0001 << code : 4'b0000;
    pend_next = (pending & ~acc_mask) | req_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (clr) state <= IDLE;
    else state <= state_d;
  end
  // IDLE looks only at the registered mask, giving the two-edge request-to-offer latency.
  always_comb begin
    state_d = state;
    if (state == IDLE) state_d = |pending ? OFFER : IDLE;
    else if (acc) state_d = |pend_next ? OFFER : IDLE;
  end
  // After an accept the just-accepted code becomes the rotation base.
  always_comb begin
    code_d = (state == IDLE) ? (|pending ? sel(pending, last) : code)
           : (acc && |pend_next) ? sel(pend_next, code) : code;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 4'b0;
      code    <= 2'd0;
      ovf     <= 1'b0;
      last    <= 2'd3;
    end else if (clr) begin
      pending <= 4'b0;
      ovf     <= 1'b0;
    end else begin
      pending <= pend_next;
      ovf     <= |(req_in & pending & ~acc_mask);
      code    <= code_d;
      if (acc) last <= code;
    end
  end
endmodule

// File: tb/tb_req_encoder4.sv
// tb_req_encoder4: directed scoreboard bench for req_encoder4 in fixed and rotating modes.
module tb_req_encoder4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       clr = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] f_code, r_code;
  logic       f_valid, r_valid, f_ovf, r_ovf;
  logic [3:0] f_pend, r_pend;
  logic       mon_f = 1'b0;
  logic       mon_r = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         qf[$];
  int         qr[$];
  always #5 clk = ~clk;
  req_encoder4 #(.ROUND_ROBIN(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_in(req), .clr(clr), .ready_in(ready),
    .code_out(f_code), .valid_out(f_valid), .pending_out(f_pend), .overflow_out(f_ovf));
  req_encoder4 #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_in(req), .clr(clr), .ready_in(ready),
    .code_out(r_code), .valid_out(r_valid), .pending_out(r_pend), .overflow_out(r_ovf));
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (mon_f && f_valid && ready) begin
      chk("f_queue_nonempty", int'(qf.size() != 0), 1);
      if (qf.size() != 0) chk("f_accepted_code", int'(f_code), qf.pop_front());
    end
    if (mon_r && r_valid && ready) begin
      chk("r_queue_nonempty", int'(qr.size() != 0), 1);
      if (qr.size() != 0) chk("r_accepted_code", int'(r_code), qr.pop_front());
    end
  end
  initial begin
    tick(); tick();
    chk("rst_valid", int'(f_valid), 0);
    chk("rst_code", int'(f_code), 0);
    chk("rst_pend", int'(f_pend), 0);
    chk("rst_ovf", int'(f_ovf), 0);
    rst_n = 1'b1; req = 4'b0100; ready = 1'b1; mon_f = 1'b1; qf.push_back(2);
    tick(); req = 4'b0;
    chk("single_pend_e1", int'(f_pend), 4);
    chk("single_valid_e1", int'(f_valid), 0);
    tick();
    chk("single_valid_e2", int'(f_valid), 1);
    chk("single_code_e2", int'(f_code), 2);
    tick();
    chk("single_valid_e3", int'(f_valid), 0);
    chk("single_pend_e3", int'(f_pend), 0);
    req = 4'b1011; qf.push_back(3); qf.push_back(1); qf.push_back(0);
    tick(); req = 4'b0;
    tick(); chk("burst_code3", int'(f_code), 3);
    tick(); chk("burst_code1", int'(f_code), 1);
    tick(); chk("burst_code0", int'(f_code), 0);
    tick(); chk("burst_done", int'(f_valid), 0);
    chk("burst_q_empty", qf.size(), 0);
    ready = 1'b0; req = 4'b0001; qf.push_back(0); qf.push_back(3);
    tick(); req = 4'b0;
    tick(); chk("hold_code0", int'(f_code), 0);
    req = 4'b1000;
    tick(); req = 4'b0;
    chk("hold_still0", int'(f_code), 0);
    chk("hold_pend", int'(f_pend), 9);
    tick(); chk("hold_still0b", int'(f_code), 0);
    ready = 1'b1;
    tick(); chk("hold_then3", int'(f_code), 3);
    chk("hold_valid", int'(f_valid), 1);
    tick(); chk("hold_done", int'(f_valid), 0);
    ready = 1'b0; req = 4'b0010; qf.push_back(1);
    tick(); req = 4'b0;
    tick(); chk("ovf_offer", int'(f_code), 1);
    req = 4'b0010;
    tick(); req = 4'b0;
    chk("ovf_pulse", int'(f_ovf), 1);
    tick(); chk("ovf_cleared", int'(f_ovf), 0);
    ready = 1'b1;
    tick(); chk("ovf_one_offer", int'(f_valid), 0);
    chk("ovf_pend", int'(f_pend), 0);
    ready = 1'b0; req = 4'b0010; qf.push_back(1); qf.push_back(1);
    tick(); req = 4'b0;
    tick(); ready = 1'b1; req = 4'b0010;
    tick(); req = 4'b0;
    chk("coll_no_ovf", int'(f_ovf), 0);
    chk("coll_valid", int'(f_valid), 1);
    chk("coll_code", int'(f_code), 1);
    chk("coll_pend", int'(f_pend), 2);
    tick(); chk("coll_done", int'(f_valid), 0);
    chk("coll_q_empty", qf.size(), 0);
    ready = 1'b0; req = 4'b0100;
    tick(); req = 4'b0;
    tick(); chk("clr_offer", int'(f_valid), 1);
    clr = 1'b1; req = 4'b1111;
    tick(); clr = 1'b0; req = 4'b0;
    chk("clr_valid", int'(f_valid), 0);
    chk("clr_pend", int'(f_pend), 0);
    chk("clr_ovf", int'(f_ovf), 0);
    tick(); chk("clr_stays_idle", int'(f_valid), 0);
    req = 4'b1000;
    tick(); req = 4'b0;
    tick(); chk("arst_offer", int'(f_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(f_valid), 0);
    chk("arst_code", int'(f_code), 0);
    chk("arst_pend", int'(f_pend), 0);
    tick(); rst_n = 1'b1; mon_f = 1'b0; mon_r = 1'b1;
    ready = 1'b1; req = 4'b1111;
    for (int k = 0; k < 5; k++) qr.push_back(k % 4);
    tick(); req = 4'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_code", int'(r_code), k % 4);
      chk("rr_valid", int'(r_valid), 1);
      req = (k < 4) ? 4'(1 << (k % 4)) : 4'b0;
    end
    tick(); mon_r = 1'b0; ready = 1'b0; req = 4'b0;
    chk("rr_q_empty", qr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/req_encoder4.md
Name: req_encoder4

Overview:
- Registered 4-to-2 request encoder: the encoding counterpart of the team's 2x4 decoder; decoder line oN maps to code N.
- Captures pulsed request lines into a pending mask.
- Presents one pending request at a time as a 2-bit code with a valid/ready handshake, and retires it on acceptance.
- Sits between interrupt/event sources and a consumer; a downstream 2x4 decoder can regenerate the one-hot acknowledge.

Parameters:
- ROUND_ROBIN, default 0: 0 = fixed priority, highest index wins; 1 = rotating priority starting after the last accepted code.
- N_REQ, default 4: number of request lines; fixed at 4, present for documentation only.
- CODE_W, default 2: code width; fixed at 2.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_in, input, 4: request pulses; each bit high at a clock edge sets its pending bit.
- clr, input, 1: synchronous flush.
- ready_in, input, 1: consumer accepts code_out this cycle.
- code_out, output, 2: encoded index of the offered request.
- valid_out, output, 1: code_out is valid.
- pending_out, output, 4: current pending mask.
- overflow_out, output, 1: one-cycle pulse when a request merges into an already-pending bit.

Behaviour:
- Reset (rst_n=0, async, immediate): pending=0, code_out=0, valid_out=0, overflow_out=0, state IDLE, rr pointer last=3.
- All outputs are registered. No combinational path from req_in or ready_in to any output.
- Accept event: acc = valid_out & ready_in at a clock edge.
- Pending update: pending_next = (pending & ~(acc ? onehot(code_out) : 0)) | req_in.
  - A request on the bit being accepted in the same cycle re-sets that bit; it counts as a new request and is not an overflow.
- Overflow: overflow_out_next = |(req_in & pending & ~acc_mask). Pulse width 1 cycle. Not sticky.
- Selection function sel(P):
  - Fixed priority: highest set index.
  - ROUND_ROBIN=1: first set index scanning last+1, last+2, ... mod 4.
  - last updates to code_out on acc only.
- Two-state FSM:
  - IDLE: valid_out=0. At an edge where pending!=0 (registered mask, not req_in): code_out<=sel(pending), valid_out<=1, go OFFER.
  - OFFER: valid_out=1; code_out held stable while ready_in=0. No preemption by a higher-priority arrival.
  - OFFER on acc: if pending_next!=0, code_out<=sel(pending_next) and valid_out stays 1 (back-to-back, one code per cycle). Otherwise valid_out<=0 and go IDLE.
- Latency:
  - req_in sampled at edge t → pending_out set after t → valid_out/code_out after edge t+1.
  - Minimum 2 edges request-to-offer from IDLE.
- clr (synchronous, highest priority below rst_n): pending<=0, valid_out<=0, overflow_out<=0, IDLE. req_in in the same cycle is discarded. The rr pointer is kept.
- ready_in while valid_out=0 is ignored.
- Reset asserted mid-handshake: the offer is dropped and all requests are lost; no acknowledge is implied.

Test Plan:
- Reset then single request: rst_n low 2 cycles, req_in=4'b0100 for 1 cycle, ready_in=1 → pending_out=0100 after edge 1; code_out=2, valid_out=1 after edge 2; valid_out=0 and pending_out=0 after edge 3.
- Fixed priority burst: req_in=4'b1011 in one cycle, ready_in=1 → codes 3,1,0 on three consecutive cycles, then valid_out=0.
- Hold/no preemption: req 0001, ready_in=0, code_out=0 offered; then req 1000 arrives → code_out stays 0 until ready_in=1, then next cycle code_out=3.
- Round robin (ROUND_ROBIN=1): requests 1111 with ready_in=1, with each bit re-requested on its accept cycle → code sequence 0,1,2,3,0.
- Overflow and same-cycle collision:
  - req 0010 while bit1 pending and not accepted → overflow_out=1 for exactly one cycle, one offer of code 1.
  - req 0010 on the accept cycle of code 1 → no overflow; code 1 offered again.
- clr and async reset:
  - clr=1 together with req_in=1111 while offering → next cycle valid_out=0, pending_out=0.
  - rst_n dropped mid-offer → outputs zero immediately, without waiting for a clock edge.
